// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM state codes,
// parity mode codes, default clocking and the parity helper.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 100_000_000;
    localparam int DEFAULT_BAUD_RATE = 9_600;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic parity_of(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter: tick on the last clk of each period and
// almost_tick one clk earlier; clear restarts the period from zero.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic almost_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'((DIV > 1) ? DIV - 2 : 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick        = (cnt_q == LAST);
    assign almost_tick = (cnt_q == PRE);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: valid/ready byte in, framed start/data/parity/stop bits
// out on TxD. Every output is a flop loaded from the next-state decode.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int   BIT_DIV   = CLK_FREQ / BAUD_RATE;
    localparam logic STOP_LAST = (STOP_BITS == 2);

    uart_state_e state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        parity_q, parity_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        txd_q, txd_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;
    logic        tick;
    logic        almost_tick;

    assign accept = tx_valid & ready_q;

    // Clearing on accept makes the start bit a full BIT_DIV clks long.
    uart_baud_tick #(
        .DIV (BIT_DIV)
    ) u_baud (
        .clk         (clk),
        .reset       (reset),
        .clear       (accept),
        .tick        (tick),
        .almost_tick (almost_tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_START;
                    shreg_d    = tx_data;
                    parity_d   = parity_of(tx_data, PARITY);
                    bit_cnt_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // tx_done is registered, so it is raised one clk ahead to land on the last stop clk.
                if (stop_cnt_q == STOP_LAST) begin
                    done_d = almost_tick;
                    if (tick) begin
                        state_d = ST_IDLE;
                    end
                end else if (tick) begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shreg_d[0];
            ST_PARITY: txd_d = parity_d;
            default:   txd_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= 8'h00;
            parity_q   <= 1'b0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TxD      = txd_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
